// File: rtl/inst_fetch.sv
// Instruction fetch unit: owns the PC, drives the ROM address, registers each
// returned instruction and sequences start / branch redirect / halt.
module inst_fetch #(
    parameter int              AW         = 11,
    parameter int              IW         = 9,
    parameter logic [AW-1:0]   START_ADDR = '0
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic          Start,
    input  logic          Stall,
    input  logic          BranchEn,
    input  logic          BranchAbs,
    input  logic [AW-1:0] Target,
    input  logic [7:0]    Offset,
    input  logic          HaltReq,
    output logic [AW-1:0] InstAddress,
    input  logic [IW-1:0] InstIn,
    output logic [IW-1:0] Instr,
    output logic          InstrValid,
    output logic [AW-1:0] InstrPC,
    output logic          Running,
    output logic          Done,
    output logic [15:0]   CycleCount
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic [IW-1:0]   instr_q, instr_d;
    logic            vld_q, vld_d;
    logic [AW-1:0]   ipc_q, ipc_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [AW-1:0]   off_ext;

    // Relative targets are taken from the branch's own address, not the PC.
    assign off_ext = {{(AW-8){Offset[7]}}, Offset};

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= IDLE;
            pc_q    <= START_ADDR;
            instr_q <= '0;
            vld_q   <= 1'b0;
            ipc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            vld_q   <= vld_d;
            ipc_q   <= ipc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        vld_d   = vld_q;
        ipc_d   = ipc_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
                if (Stall) begin
                    // Stall wins over branch/halt; only the cycle counter moves.
                end else if (HaltReq && vld_q) begin
                    state_d = DONE;
                    vld_d   = 1'b0;
                end else if (BranchEn && vld_q) begin
                    pc_d  = BranchAbs ? Target : ipc_q + off_ext;
                    vld_d = 1'b0;
                end else begin
                    instr_d = InstIn;
                    ipc_d   = pc_q;
                    vld_d   = 1'b1;
                    pc_d    = pc_q + {{(AW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                vld_d = 1'b0;
                if (Start) begin
                    pc_d    = START_ADDR;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
        endcase
    end

    assign InstAddress = pc_q;
    assign Instr       = instr_q;
    assign InstrValid  = vld_q;
    assign InstrPC     = ipc_q;
    assign Running     = (state_q == RUN);
    assign Done        = (state_q == DONE);
    assign CycleCount  = cnt_q;

endmodule
